// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game datapath: colour encoding,
// round sizing and the player input capture state encoding.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COLOUR_SW0 = 2'b00;
    localparam colour_t COLOUR_SW1 = 2'b01;
    localparam colour_t COLOUR_SW2 = 2'b10;
    localparam colour_t COLOUR_SW3 = 2'b11;

    localparam int unsigned MAX_ROUNDS = 33;
    localparam int unsigned IDX_W      = $clog2(MAX_ROUNDS + 1);

    typedef enum logic [2:0] {
        CAP_IDLE         = 3'd0,
        CAP_ARMED        = 3'd1,
        CAP_WAIT_PRESS   = 3'd2,
        CAP_DEBOUNCE     = 3'd3,
        CAP_WAIT_RELEASE = 3'd4
    } capture_state_e;

    function automatic logic is_onehot(input logic [3:0] p);
        return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for one-hot patterns; anything else maps to SW0.
    function automatic colour_t onehot_to_colour(input logic [3:0] p);
        colour_t c;
        case (p)
            4'b0010: c = COLOUR_SW1;
            4'b0100: c = COLOUR_SW2;
            4'b1000: c = COLOUR_SW3;
            default: c = COLOUR_SW0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/player_input_capture_if.sv
// Control/result bus between the game fsm, player_input_capture and verify_input.
interface player_input_capture_if;
    import simon_pkg::*;

    logic             start;
    logic [IDX_W-1:0] round_len;
    logic             abort;
    colour_t          colour_o;
    logic             colour_valid;
    logic [IDX_W-1:0] entry_idx;
    logic             multi_err;
    logic             done;
    logic             timeout;
    logic             busy;

    modport master (
        output start, round_len, abort,
        input  colour_o, colour_valid, entry_idx, multi_err, done, timeout, busy
    );

    modport slave (
        input  start, round_len, abort,
        output colour_o, colour_valid, entry_idx, multi_err, done, timeout, busy
    );
endinterface

// File: rtl/player_input_capture_stable_detect.sv
// Two-flop switch synchroniser plus a saturating counter that reports when
// the synchronised pattern has matched ref_pat for N consecutive cycles.
module stable_detect #(
    parameter int unsigned N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic [3:0] ref_pat,
    input  logic       clear,
    output logic [3:0] ss,
    output logic       stable_c
);
    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [3:0]    s1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 4'd0;
            ss  <= 4'd0;
            cnt <= '0;
        end else begin
            s1 <= sw;
            ss <= s1;
            if (clear || (ss != ref_pat)) begin
                cnt <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign stable_c = (ss == ref_pat) && (cnt == LAST);
endmodule

// File: rtl/player_input_capture.sv
// Captures one debounced colour entry per switch press-and-release during the
// player's turn. Optional macro INPUT_TIMEOUT_EN enables the idle-press timeout.
module player_input_capture
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             sw,
    player_input_capture_if.slave  bus
);
    localparam logic [2:0] S_IDLE         = 3'(CAP_IDLE);
    localparam logic [2:0] S_ARMED        = 3'(CAP_ARMED);
    localparam logic [2:0] S_WAIT_PRESS   = 3'(CAP_WAIT_PRESS);
    localparam logic [2:0] S_DEBOUNCE     = 3'(CAP_DEBOUNCE);
    localparam logic [2:0] S_WAIT_RELEASE = 3'(CAP_WAIT_RELEASE);

    logic [2:0]       state, state_next;
    logic [IDX_W-1:0] round_len_q, round_len_next;
    logic [IDX_W-1:0] count_q, count_next;
    logic [3:0]       pattern_q, pattern_next;
    colour_t          colour_q, colour_next;
    logic [IDX_W-1:0] idx_q, idx_next;
    logic             valid_q, valid_next;
    logic             multi_q, multi_next;
    logic             done_q, done_next;
    logic             timeout_q, timeout_next;
    logic             busy_q;

    logic [3:0]       ss;
    logic [3:0]       ref_pat_c;
    logic             stable_c;
    logic             clear_c;

    // One stability checker serves ARMED/WAIT_RELEASE (all off) and DEBOUNCE (latched pattern).
    assign ref_pat_c = (state == S_DEBOUNCE) ? pattern_q : 4'd0;
    assign clear_c   = (state_next != state);

    stable_detect #(.N(DEBOUNCE_CYCLES)) u_stable (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .ref_pat  (ref_pat_c),
        .clear    (clear_c),
        .ss       (ss),
        .stable_c (stable_c)
    );

`ifdef INPUT_TIMEOUT_EN
    localparam int unsigned        TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit_c;

    // Idle-press counter: zero outside WAIT_PRESS, so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (reset || (state != S_WAIT_PRESS)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit_c = (tmo_cnt == TMO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            round_len_q <= '0;
            count_q     <= '0;
            pattern_q   <= 4'd0;
            colour_q    <= COLOUR_SW0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            multi_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            round_len_q <= round_len_next;
            count_q     <= count_next;
            pattern_q   <= pattern_next;
            colour_q    <= colour_next;
            idx_q       <= idx_next;
            valid_q     <= valid_next;
            multi_q     <= multi_next;
            done_q      <= done_next;
            timeout_q   <= timeout_next;
            busy_q      <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next     = state;
        round_len_next = round_len_q;
        count_next     = count_q;
        pattern_next   = pattern_q;
        colour_next    = colour_q;
        idx_next       = idx_q;
        valid_next     = 1'b0;
        multi_next     = 1'b0;
        done_next      = 1'b0;
        timeout_next   = 1'b0;

        // abort overrides every transition and suppresses all pulses
        if (bus.abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        round_len_next = bus.round_len;
                        count_next     = '0;
                        if (bus.round_len == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (stable_c) begin
                        state_next = S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (ss != 4'd0) begin
                        pattern_next = ss;
                        state_next   = S_DEBOUNCE;
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (tmo_hit_c) begin
                        timeout_next = 1'b1;
                        state_next   = S_IDLE;
                    end
`endif
                end
                S_DEBOUNCE: begin
                    if (ss != pattern_q) begin
                        state_next = S_WAIT_PRESS;
                    end else if (stable_c) begin
                        if (is_onehot(pattern_q)) begin
                            valid_next  = 1'b1;
                            colour_next = onehot_to_colour(pattern_q);
                            idx_next    = count_q;
                            if (count_q != '1) begin
                                count_next = count_q + IDX_W'(1);
                            end
                        end else begin
                            multi_next = 1'b1;
                        end
                        state_next = S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (stable_c) begin
                        if (count_q == round_len_q) begin
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_WAIT_PRESS;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign bus.colour_o     = colour_q;
    assign bus.colour_valid = valid_q;
    assign bus.entry_idx    = idx_q;
    assign bus.multi_err    = multi_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_player_input_capture.sv
// Directed bench for player_input_capture with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_player_input_capture;
    import simon_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 50;
    localparam int          LAT = 2 + DEB + 1;

    logic       clk;
    logic       reset;
    logic [3:0] sw;

    player_input_capture_if bus();

    player_input_capture #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_start;
        logic [5:0] len;
        logic [3:0] pat;
        int         exp_valid;
        logic [1:0] exp_col;
        logic [5:0] exp_idx;
        int         exp_multi;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid, n_multi, n_done, n_tmo;
    int last_valid_cyc;
    int t0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling outputs 1 ns after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.colour_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (bus.multi_err === 1'b1) n_multi++;
            if (bus.done === 1'b1) n_done++;
            if (bus.timeout === 1'b1) n_tmo++;
        end
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_multi = 0;
        n_done  = 0;
        n_tmo   = 0;
        last_valid_cyc = -1;
    endtask

    task automatic pulse_start(input logic [5:0] len);
        bus.start     = 1'b1;
        bus.round_len = len;
        step(1);
        bus.start     = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_colour_o"},     int'(bus.colour_o),     0);
        check({tag, "_colour_valid"}, int'(bus.colour_valid), 0);
        check({tag, "_entry_idx"},    int'(bus.entry_idx),    0);
        check({tag, "_multi_err"},    int'(bus.multi_err),    0);
        check({tag, "_done"},         int'(bus.done),         0);
        check({tag, "_timeout"},      int'(bus.timeout),      0);
        check({tag, "_busy"},         int'(bus.busy),         0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 6'd3, 4'b0001, 1, 2'b00, 6'd0, 0, 0};
        vecs[1] = '{1'b0, 6'd0, 4'b0100, 1, 2'b10, 6'd1, 0, 0};
        vecs[2] = '{1'b0, 6'd0, 4'b1000, 1, 2'b11, 6'd2, 0, 1};
        vecs[3] = '{1'b1, 6'd2, 4'b0011, 0, 2'b11, 6'd2, 1, 0};
        vecs[4] = '{1'b0, 6'd0, 4'b0001, 1, 2'b00, 6'd0, 0, 0};
        vecs[5] = '{1'b0, 6'd0, 4'b0010, 1, 2'b01, 6'd1, 0, 1};
        vecs[6] = '{1'b1, 6'd1, 4'b1111, 0, 2'b01, 6'd1, 1, 0};
        vecs[7] = '{1'b0, 6'd0, 4'b1000, 1, 2'b11, 6'd0, 0, 1};

        reset         = 1'b1;
        sw            = 4'd0;
        bus.start     = 1'b0;
        bus.round_len = 6'd0;
        bus.abort     = 1'b0;
        clear_counts();
        step(3);
        reset = 1'b0;
        step(1);
        check_outputs_zero("reset");

        // Table-driven rounds: each row is one press/release, optionally preceded by a start.
        for (int i = 0; i < 8; i++) begin
            clear_counts();
            if (vecs[i].do_start) begin
                pulse_start(vecs[i].len);
                step(10);
            end
            sw = vecs[i].pat;
            t0 = cyc;
            step(10);
            sw = 4'd0;
            step(10);
            check($sformatf("row%0d_valid_cnt", i), n_valid, vecs[i].exp_valid);
            check($sformatf("row%0d_multi_cnt", i), n_multi, vecs[i].exp_multi);
            check($sformatf("row%0d_done_cnt", i),  n_done,  vecs[i].exp_done);
            check($sformatf("row%0d_colour", i),    int'(bus.colour_o),  int'(vecs[i].exp_col));
            check($sformatf("row%0d_idx", i),       int'(bus.entry_idx), int'(vecs[i].exp_idx));
            check($sformatf("row%0d_busy", i),      int'(bus.busy),      (vecs[i].exp_done != 0) ? 0 : 1);
            if (vecs[i].exp_valid != 0)
                check($sformatf("row%0d_latency", i), last_valid_cyc - t0, LAT);
        end

        // Bouncy press: one-cycle drop mid-debounce restarts the stability window.
        clear_counts();
        pulse_start(6'd1);
        step(10);
        sw = 4'b0010;
        step(4);
        sw = 4'b0000;
        step(1);
        sw = 4'b0010;
        t0 = cyc;
        step(12);
        check("bounce_valid_cnt", n_valid, 1);
        check("bounce_colour", int'(bus.colour_o), 1);
        check("bounce_latency", last_valid_cyc - t0, LAT);
        sw = 4'd0;
        step(10);
        check("bounce_done_cnt", n_done, 1);

        // Switch already on when the round starts must be ignored until released.
        clear_counts();
        sw = 4'b0100;
        step(5);
        pulse_start(6'd1);
        step(20);
        check("held_valid_cnt", n_valid, 0);
        check("held_busy", int'(bus.busy), 1);
        sw = 4'd0;
        step(10);
        check("held_release_valid_cnt", n_valid, 0);
        sw = 4'b0100;
        step(10);
        check("held_repress_valid_cnt", n_valid, 1);
        check("held_repress_colour", int'(bus.colour_o), 2);
        check("held_repress_idx", int'(bus.entry_idx), 0);
        sw = 4'd0;
        step(10);
        check("held_done_cnt", n_done, 1);

        // Abort landing on the debounce completion cycle suppresses the entry.
        clear_counts();
        pulse_start(6'd2);
        step(10);
        sw = 4'b0001;
        step(LAT - 1);
        pulse_abort();
        step(5);
        check("abort_valid_cnt", n_valid, 0);
        check("abort_busy", int'(bus.busy), 0);
        sw = 4'd0;
        step(10);
        check("abort_after_valid_cnt", n_valid, 0);

        // Synchronous reset mid-round clears every output.
        clear_counts();
        pulse_start(6'd2);
        step(10);
        sw = 4'b1000;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_outputs_zero("midreset");
        step(10);
        check("midreset_valid_cnt", n_valid, 0);
        sw = 4'd0;
        step(5);

        // Zero-length round finishes on the cycle after start.
        clear_counts();
        pulse_start(6'd0);
        check("zero_len_done_now", int'(bus.done), 1);
        check("zero_len_busy", int'(bus.busy), 0);
        step(3);
        check("zero_len_done_cnt", n_done, 1);

        // No press for longer than the timeout window.
        clear_counts();
        pulse_start(6'd1);
        step(10 + TMO + 10);
`ifdef INPUT_TIMEOUT_EN
        check("timeout_cnt", n_tmo, 1);
        check("timeout_busy", int'(bus.busy), 0);
`else
        check("timeout_cnt", n_tmo, 0);
        check("timeout_busy", int'(bus.busy), 1);
`endif
        pulse_abort();
        step(2);
        check("final_busy", int'(bus.busy), 0);
        check("final_valid_cnt", n_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
